tdm_demux_4: RTL

- Receive end of the 4:1 channel multiplexer (mux_4_1). Takes one time-multiplexed sample stream and splits it into four channel outputs.
- Tracks the slot select (s1,s0) internally and locks to a frame-sync marker.
- Captures one sample per slot into a shadow buffer.
- Publishes all four channels atomically at the end of each frame, with a one-cycle frame_valid pulse.

---
 rtl/tdm_pkg.sv | 24 ++
 rtl/tdm_demux_4_slot_counter.sv | 41 ++++
 rtl/tdm_demux_4.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the tdm_demux_4 receive path.
// Slot encodings, FSM states and a last-slot helper.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

    function automatic logic is_last(
        input logic [SLOT_W-1:0] s
    );
        return s == SLOT3;
    endfunction

endpackage

// File: rtl/tdm_demux_4_slot_counter.sv
// slot_counter: modulo-4 slot index for the demux.
// Load forces slot 01 (sync sample is slot 0), inc advances, else hold.
module slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              s1_o,
    output logic              s0_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    // Next slot: load has priority over increment; idle holds.
    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = SLOT1;
        end else if (inc_i) begin
            slot_d = slot_q + 1'b1;
        end
    end

    // Slot register, cleared to slot 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign s1_o   = slot_q[1];
    assign s0_o   = slot_q[0];

endmodule

// File: rtl/tdm_demux_4.sv
// tdm_demux_4: splits a 4-slot TDM stream into four channels.
// Locks on frame_sync, buffers slots 0..2, publishes whole frames.
module tdm_demux_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             sync_err
);

    state_e            state_q;
    state_e            state_d;
    logic [SLOT_W-1:0] slot;
    logic              load;
    logic              inc;
    logic              publish;
    logic              err;
    logic              locked_q;
    logic              fv_q;
    logic              err_q;
    logic [WIDTH-1:0]  y_q [NUM_SLOTS];
    // Slot 3 goes straight to y3, so only slots 0..2 are buffered.
    logic [WIDTH-1:0]  shadow_q [NUM_SLOTS-1];

    slot_counter u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .inc_i  (inc),
        .slot_o (slot),
        .s1_o   (s1),
        .s0_o   (s0)
    );

    // Decode the accepted sample into counter, buffer and publish actions.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        inc     = 1'b0;
        publish = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    load    = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    if (frame_sync) begin
                        load = 1'b1;
                        err  = (slot != SLOT0);
                    end else begin
                        inc     = 1'b1;
                        publish = is_last(slot);
                    end
                end
            end
        endcase
    end

    // Shadow buffer: sync sample lands in slot 0, others at the slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                if ((load && i == 0) ||
                    (inc && slot == SLOT_W'(i))) begin
                    shadow_q[i] <= din;
                end
            end
        end
    end

    // FSM with registered status pulses and the published channel set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            locked_q <= (state_d == LOCKED);
            fv_q     <= publish;
            err_q    <= err;
            if (publish) begin
                y_q[0] <= shadow_q[0];
                y_q[1] <= shadow_q[1];
                y_q[2] <= shadow_q[2];
                y_q[3] <= din;
            end
        end
    end

    assign y0          = y_q[0];
    assign y1          = y_q[1];
    assign y2          = y_q[2];
    assign y3          = y_q[3];
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;

endmodule
